// File: rtl/swt16_pkg.sv
// Shared definitions for the swt16 pipeline memory stage.
// Holds the default widths and the state encoding of the memory-stage FSM.
package swt16_pkg;

    localparam int unsigned DmemAddrWidth  = 12;
    localparam int unsigned DmemWordWidth  = 16;
    localparam int unsigned IaluWordWidth  = 16;
    localparam int unsigned PcWidth        = 12;
    localparam int unsigned PmemWordWidth  = 16;
    localparam int unsigned RegIdxWidth    = 4;
    localparam int unsigned MaxWaitDefault = 15;

    // Memory-stage FSM: idle, waiting on the data memory, one-cycle completion.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StDone = 2'd2
    } mem_state_e;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive data-memory wait cycles and flags the cycle in which the
// count reaches MaxWait.
// Ports:
//   clk_i     - clock, rising edge
//   rst_ni    - asynchronous active-low reset
//   clear_i   - return the count to zero (has priority over enable_i)
//   enable_i  - this cycle is a wait cycle (request pending, no ack)
//   expired_o - this wait cycle is the MaxWait-th one; count reaches MaxWait
module mem_wait_timer #(
    parameter int unsigned MaxWait = 15
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int unsigned CntW = (MaxWait < 2) ? 1 : $clog2(MaxWait + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(MaxWait - 1);

    logic [CntW-1:0] count_q;
    logic [CntW-1:0] count_d;

    // Count already holds MaxWait-1 completed wait cycles, so this one is the last.
    assign expired_o = enable_i && !clear_i && (count_q == LastCnt);

    always_comb begin
        count_d = count_q;
        if (clear_i || expired_o) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/memory.sv
// Memory pipeline stage. Passes ALU results straight through with one cycle of
// latency, and turns load/store actions into a held request on the data-memory
// port, stalling upstream until the memory acks or the wait budget runs out.
// Ports:
//   clock, reset              - rising-edge clock, asynchronous active-low reset
//   in_act_*                  - exec-stage action flags (load, store, register write)
//   in_dmem_rd_addr           - load address
//   in_dmem_wr_addr/_wr_word  - store address and data
//   in_instr, in_pc           - instruction word and PC carried down the pipe
//   in_res, in_res_reg_idx    - ALU result and destination register
//   dmem_ack, dmem_rdata      - data-memory response
//   dmem_req/_we/_addr/_wdata - data-memory request, held stable until ack
//   out_stall                 - upstream must hold its outputs
//   out_act_write_res_to_reg  - one-cycle register-write strobe
//   out_res, out_res_reg_idx  - write-back value and register
//   out_instr, out_pc         - instruction word and PC passed on
//   out_dmem_timeout          - sticky: a request was abandoned for lack of ack
module memory
    import swt16_pkg::*;
#(
    parameter int unsigned DMEM_ADDR_WIDTH = DmemAddrWidth,
    parameter int unsigned DMEM_WORD_WIDTH = DmemWordWidth,
    parameter int unsigned IALU_WORD_WIDTH = IaluWordWidth,
    parameter int unsigned PC_WIDTH        = PcWidth,
    parameter int unsigned PMEM_WORD_WIDTH = PmemWordWidth,
    parameter int unsigned REG_IDX_WIDTH   = RegIdxWidth,
    parameter int unsigned MAX_WAIT        = MaxWaitDefault
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_act_load_dmem,
    input  logic                       in_act_store_dmem,
    input  logic                       in_act_write_res_to_reg,
    input  logic [DMEM_ADDR_WIDTH-1:0] in_dmem_rd_addr,
    input  logic [DMEM_ADDR_WIDTH-1:0] in_dmem_wr_addr,
    input  logic [DMEM_WORD_WIDTH-1:0] in_dmem_wr_word,
    input  logic [PMEM_WORD_WIDTH-1:0] in_instr,
    input  logic [PC_WIDTH-1:0]        in_pc,
    input  logic [IALU_WORD_WIDTH-1:0] in_res,
    input  logic [REG_IDX_WIDTH-1:0]   in_res_reg_idx,
    input  logic                       dmem_ack,
    input  logic [DMEM_WORD_WIDTH-1:0] dmem_rdata,
    output logic                       dmem_req,
    output logic                       dmem_we,
    output logic [DMEM_ADDR_WIDTH-1:0] dmem_addr,
    output logic [DMEM_WORD_WIDTH-1:0] dmem_wdata,
    output logic                       out_stall,
    output logic                       out_act_write_res_to_reg,
    output logic [IALU_WORD_WIDTH-1:0] out_res,
    output logic [REG_IDX_WIDTH-1:0]   out_res_reg_idx,
    output logic [PMEM_WORD_WIDTH-1:0] out_instr,
    output logic [PC_WIDTH-1:0]        out_pc,
    output logic                       out_dmem_timeout
);

    mem_state_e                 state_q;
    logic                       stall_q;
    logic                       req_q;
    logic                       we_q;
    logic [DMEM_ADDR_WIDTH-1:0] addr_q;
    logic [DMEM_WORD_WIDTH-1:0] wdata_q;
    logic                       is_load_q;   // pending access is a load
    logic                       wr_pend_q;   // register write owed once the access completes
    logic                       act_wr_q;
    logic [IALU_WORD_WIDTH-1:0] res_q;
    logic [REG_IDX_WIDTH-1:0]   idx_q;
    logic [PMEM_WORD_WIDTH-1:0] instr_q;
    logic [PC_WIDTH-1:0]        pc_q;
    logic                       timeout_q;

    logic ack_valid;
    logic timer_clear;
    logic timer_en;
    logic timer_expired;

    // An ack only means something while a request is actually on the bus.
    assign ack_valid   = dmem_ack && req_q;
    assign timer_clear = (state_q != StReq);
    assign timer_en    = (state_q == StReq) && !ack_valid;

    mem_wait_timer #(
        .MaxWait (MAX_WAIT)
    ) u_wait_timer (
        .clk_i     (clock),
        .rst_ni    (reset),
        .clear_i   (timer_clear),
        .enable_i  (timer_en),
        .expired_o (timer_expired)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            stall_q   <= 1'b0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            is_load_q <= 1'b0;
            wr_pend_q <= 1'b0;
            act_wr_q  <= 1'b0;
            res_q     <= '0;
            idx_q     <= '0;
            instr_q   <= '0;
            pc_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            unique case (state_q)
                StReq: begin
                    if (ack_valid) begin
                        state_q  <= StDone;
                        stall_q  <= 1'b0;
                        req_q    <= 1'b0;
                        we_q     <= 1'b0;
                        addr_q   <= '0;
                        wdata_q  <= '0;
                        act_wr_q <= wr_pend_q;
                        if (is_load_q) begin
                            res_q <= IALU_WORD_WIDTH'(dmem_rdata);
                        end
                    end else if (timer_expired) begin
                        // Abandon the access: no write-back, remember it happened.
                        state_q   <= StDone;
                        stall_q   <= 1'b0;
                        req_q     <= 1'b0;
                        we_q      <= 1'b0;
                        addr_q    <= '0;
                        wdata_q   <= '0;
                        act_wr_q  <= 1'b0;
                        timeout_q <= 1'b1;
                    end
                end
                default: begin
                    // StIdle and StDone both accept a new instruction every edge.
                    instr_q <= in_instr;
                    pc_q    <= in_pc;
                    idx_q   <= in_res_reg_idx;
                    res_q   <= in_res;
                    if (in_act_load_dmem || in_act_store_dmem) begin
                        state_q   <= StReq;
                        stall_q   <= 1'b1;
                        req_q     <= 1'b1;
                        act_wr_q  <= 1'b0;
                        wr_pend_q <= in_act_write_res_to_reg;
                        // Store wins when both are flagged; the load is dropped.
                        is_load_q <= !in_act_store_dmem;
                        we_q      <= in_act_store_dmem;
                        addr_q    <= in_act_store_dmem ? in_dmem_wr_addr : in_dmem_rd_addr;
                        wdata_q   <= in_act_store_dmem ? in_dmem_wr_word : '0;
                    end else begin
                        state_q  <= StIdle;
                        act_wr_q <= in_act_write_res_to_reg;
                    end
                end
            endcase
        end
    end

    assign dmem_req                 = req_q;
    assign dmem_we                  = we_q;
    assign dmem_addr                = addr_q;
    assign dmem_wdata               = wdata_q;
    assign out_stall                = stall_q;
    assign out_act_write_res_to_reg = act_wr_q;
    assign out_res                  = res_q;
    assign out_res_reg_idx          = idx_q;
    assign out_instr                = instr_q;
    assign out_pc                   = pc_q;
    assign out_dmem_timeout         = timeout_q;

endmodule

// File: tb/tb_memory.sv
// Directed bench for the memory stage: ALU pass-through, load with wait states,
// minimum-latency load and store, load+store conflict, timeout and mid-request reset.
module tb_memory;

    logic        clock;
    logic        reset;
    logic        in_act_load_dmem;
    logic        in_act_store_dmem;
    logic        in_act_write_res_to_reg;
    logic [11:0] in_dmem_rd_addr;
    logic [11:0] in_dmem_wr_addr;
    logic [15:0] in_dmem_wr_word;
    logic [15:0] in_instr;
    logic [11:0] in_pc;
    logic [15:0] in_res;
    logic [3:0]  in_res_reg_idx;
    logic        dmem_ack;
    logic [15:0] dmem_rdata;
    logic        dmem_req;
    logic        dmem_we;
    logic [11:0] dmem_addr;
    logic [15:0] dmem_wdata;
    logic        out_stall;
    logic        out_act_write_res_to_reg;
    logic [15:0] out_res;
    logic [3:0]  out_res_reg_idx;
    logic [15:0] out_instr;
    logic [11:0] out_pc;
    logic        out_dmem_timeout;

    int n_checks = 0;
    int n_errors = 0;

    // Per-cycle event counters, only ever written here.
    int req_cnt    = 0;
    int stall_cnt  = 0;
    int strobe_cnt = 0;
    int we_cnt     = 0;
    int ldaddr_cnt = 0;
    logic [11:0] watch_addr = 12'h0AA;

    memory u_dut (
        .clock                    (clock),
        .reset                    (reset),
        .in_act_load_dmem         (in_act_load_dmem),
        .in_act_store_dmem        (in_act_store_dmem),
        .in_act_write_res_to_reg  (in_act_write_res_to_reg),
        .in_dmem_rd_addr          (in_dmem_rd_addr),
        .in_dmem_wr_addr          (in_dmem_wr_addr),
        .in_dmem_wr_word          (in_dmem_wr_word),
        .in_instr                 (in_instr),
        .in_pc                    (in_pc),
        .in_res                   (in_res),
        .in_res_reg_idx           (in_res_reg_idx),
        .dmem_ack                 (dmem_ack),
        .dmem_rdata               (dmem_rdata),
        .dmem_req                 (dmem_req),
        .dmem_we                  (dmem_we),
        .dmem_addr                (dmem_addr),
        .dmem_wdata               (dmem_wdata),
        .out_stall                (out_stall),
        .out_act_write_res_to_reg (out_act_write_res_to_reg),
        .out_res                  (out_res),
        .out_res_reg_idx          (out_res_reg_idx),
        .out_instr                (out_instr),
        .out_pc                   (out_pc),
        .out_dmem_timeout         (out_dmem_timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (dmem_req) req_cnt++;
        if (out_stall) stall_cnt++;
        if (out_act_write_res_to_reg) strobe_cnt++;
        if (dmem_req && dmem_we) we_cnt++;
        if (dmem_req && dmem_addr == watch_addr) ldaddr_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        in_act_load_dmem        = 1'b0;
        in_act_store_dmem       = 1'b0;
        in_act_write_res_to_reg = 1'b0;
        in_dmem_rd_addr         = '0;
        in_dmem_wr_addr         = '0;
        in_dmem_wr_word         = '0;
        in_instr                = '0;
        in_pc                   = '0;
        in_res                  = '0;
        in_res_reg_idx          = '0;
        dmem_ack                = 1'b0;
        dmem_rdata              = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int b_req, b_stall, b_strobe, b_we, b_ld;
        idle_inputs();
        reset = 1'b0;
        #3;
        check("rst_req", dmem_req, 0);
        check("rst_stall", out_stall, 0);
        check("rst_strobe", out_act_write_res_to_reg, 0);
        check("rst_res", out_res, 0);
        check("rst_timeout", out_dmem_timeout, 0);
        #9 reset = 1'b1;
        tick();

        // ALU pass-through, latency 1, single strobe.
        in_res = 16'h1234; in_res_reg_idx = 4'd3; in_act_write_res_to_reg = 1'b1;
        in_instr = 16'hA5A5; in_pc = 12'h100;
        tick();
        check("alu_strobe", out_act_write_res_to_reg, 1);
        check("alu_res", out_res, 16'h1234);
        check("alu_idx", out_res_reg_idx, 3);
        check("alu_instr", out_instr, 16'hA5A5);
        check("alu_pc", out_pc, 12'h100);
        check("alu_noreq", dmem_req, 0);
        check("alu_nostall", out_stall, 0);
        idle_inputs();
        in_res = 16'h5678;
        tick();
        check("alu_strobe_once", out_act_write_res_to_reg, 0);
        check("alu_res_nowrite", out_res, 16'h5678);
        idle_inputs();
        tick();

        // Load, ack in the third request cycle.
        b_req = req_cnt; b_stall = stall_cnt; b_strobe = strobe_cnt;
        in_act_load_dmem = 1'b1; in_act_write_res_to_reg = 1'b1;
        in_dmem_rd_addr = 12'h010; in_dmem_wr_addr = 12'h555; in_dmem_wr_word = 16'h9999;
        in_res_reg_idx = 4'd5; in_res = 16'h7777;
        tick();
        check("ld_req", dmem_req, 1);
        check("ld_we", dmem_we, 0);
        check("ld_addr", dmem_addr, 12'h010);
        check("ld_wdata", dmem_wdata, 0);
        check("ld_stall", out_stall, 1);
        check("ld_nostrobe", out_act_write_res_to_reg, 0);
        tick();
        check("ld_addr_hold", dmem_addr, 12'h010);
        tick();
        dmem_ack = 1'b1; dmem_rdata = 16'hBEEF;
        tick();
        idle_inputs();
        check("ld_strobe", out_act_write_res_to_reg, 1);
        check("ld_res", out_res, 16'hBEEF);
        check("ld_idx", out_res_reg_idx, 5);
        check("ld_req_drop", dmem_req, 0);
        check("ld_stall_drop", out_stall, 0);
        tick();
        check("ld_strobe_once", out_act_write_res_to_reg, 0);
        check("ld_req_cycles", req_cnt - b_req, 3);
        check("ld_stall_cycles", stall_cnt - b_stall, 3);
        check("ld_strobe_cycles", strobe_cnt - b_strobe, 1);

        // Minimum-latency load: strobe two edges after sampling.
        in_act_load_dmem = 1'b1; in_act_write_res_to_reg = 1'b1;
        in_dmem_rd_addr = 12'h011; in_res_reg_idx = 4'd2;
        tick();
        check("ldmin_nostrobe", out_act_write_res_to_reg, 0);
        dmem_ack = 1'b1; dmem_rdata = 16'hCAFE;
        tick();
        idle_inputs();
        check("ldmin_strobe", out_act_write_res_to_reg, 1);
        check("ldmin_res", out_res, 16'hCAFE);
        tick();

        // Store, ack in first cycle, no write flag.
        b_req = req_cnt; b_stall = stall_cnt; b_strobe = strobe_cnt; b_we = we_cnt;
        in_act_store_dmem = 1'b1; in_dmem_wr_addr = 12'h020; in_dmem_wr_word = 16'h00FF;
        in_dmem_rd_addr = 12'h3AB;
        tick();
        check("st_we", dmem_we, 1);
        check("st_addr", dmem_addr, 12'h020);
        check("st_wdata", dmem_wdata, 16'h00FF);
        dmem_ack = 1'b1;
        tick();
        idle_inputs();
        check("st_nostall", out_stall, 0);
        check("st_noreq", dmem_req, 0);
        check("st_nostrobe", out_act_write_res_to_reg, 0);
        tick();
        check("st_we_cycles", we_cnt - b_we, 1);
        check("st_stall_cycles", stall_cnt - b_stall, 1);
        check("st_strobe_cycles", strobe_cnt - b_strobe, 0);

        // Load and store together: store only, load address never on the bus.
        b_ld = ldaddr_cnt; b_strobe = strobe_cnt;
        in_act_load_dmem = 1'b1; in_act_store_dmem = 1'b1;
        in_dmem_rd_addr = 12'h0AA; in_dmem_wr_addr = 12'h0BB; in_dmem_wr_word = 16'h1357;
        tick();
        check("ldst_addr", dmem_addr, 12'h0BB);
        check("ldst_we", dmem_we, 1);
        check("ldst_wdata", dmem_wdata, 16'h1357);
        dmem_ack = 1'b1; dmem_rdata = 16'hDEAD;
        tick();
        idle_inputs();
        tick();
        check("ldst_no_ldaddr", ldaddr_cnt - b_ld, 0);
        check("ldst_nostrobe", strobe_cnt - b_strobe, 0);

        // Load with no ack: request held for 15 cycles, then timeout.
        b_req = req_cnt; b_strobe = strobe_cnt;
        in_act_load_dmem = 1'b1; in_act_write_res_to_reg = 1'b1; in_dmem_rd_addr = 12'h040;
        tick();
        for (int i = 0; i < 14; i++) tick();
        check("to_req_last", dmem_req, 1);
        check("to_flag_pre", out_dmem_timeout, 0);
        idle_inputs();
        tick();
        check("to_req_drop", dmem_req, 0);
        check("to_flag", out_dmem_timeout, 1);
        check("to_nostrobe", out_act_write_res_to_reg, 0);
        check("to_nostall", out_stall, 0);
        tick();
        tick();
        check("to_sticky", out_dmem_timeout, 1);
        check("to_req_cycles", req_cnt - b_req, 15);
        check("to_strobe_cycles", strobe_cnt - b_strobe, 0);

        // Reset in the middle of a request.
        in_act_load_dmem = 1'b1; in_act_write_res_to_reg = 1'b1;
        in_dmem_rd_addr = 12'h066; in_res = 16'h4444;
        tick();
        tick();
        check("mr_req_before", dmem_req, 1);
        #2 reset = 1'b0;
        #1;
        check("mr_req", dmem_req, 0);
        check("mr_stall", out_stall, 0);
        check("mr_timeout", out_dmem_timeout, 0);
        check("mr_res", out_res, 0);
        check("mr_strobe", out_act_write_res_to_reg, 0);
        idle_inputs();
        #2 reset = 1'b1;
        tick();
        tick();
        check("mr_idle_req", dmem_req, 0);
        check("mr_idle_stall", out_stall, 0);
        check("mr_idle_strobe", out_act_write_res_to_reg, 0);
        in_res = 16'h0042; in_res_reg_idx = 4'd7; in_act_write_res_to_reg = 1'b1;
        tick();
        idle_inputs();
        check("mr_alu_strobe", out_act_write_res_to_reg, 1);
        check("mr_alu_res", out_res, 16'h0042);
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/memory.md
MEMORY -- requirements
Module: memory

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
  DMEM_ADDR_WIDTH  12  data-memory address width
  DMEM_WORD_WIDTH  16  data-memory word width
  IALU_WORD_WIDTH  16  result word width
  PC_WIDTH         12  program-counter width
  PMEM_WORD_WIDTH  16  instruction word width
  REG_IDX_WIDTH     4  register index width
  MAX_WAIT         15  max dmem wait cycles before timeout
REQ-002 Ports SHALL be (name, direction, width, meaning):
  clock  in  1  single clock; all state rising-edge
  reset  in  1  asynchronous, active-low reset
  in_act_load_dmem / in_act_store_dmem / in_act_write_res_to_reg  in  1 each  exec-stage action flags
  in_dmem_rd_addr  in  DMEM_ADDR_WIDTH  load address
  in_dmem_wr_addr  in  DMEM_ADDR_WIDTH  store address
  in_dmem_wr_word  in  DMEM_WORD_WIDTH  store data
  in_instr  in  PMEM_WORD_WIDTH;  in_pc  in  PC_WIDTH;  in_res  in  IALU_WORD_WIDTH;  in_res_reg_idx  in  REG_IDX_WIDTH
  dmem_ack  in  1;  dmem_rdata  in  DMEM_WORD_WIDTH  memory response
  dmem_req  out  1;  dmem_we  out  1;  dmem_addr  out  DMEM_ADDR_WIDTH;  dmem_wdata  out  DMEM_WORD_WIDTH  memory request
  out_stall  out  1  upstream hold request
  out_act_write_res_to_reg  out  1  one-cycle register-write strobe
  out_res  out  IALU_WORD_WIDTH;  out_res_reg_idx  out  REG_IDX_WIDTH;  out_instr  out  PMEM_WORD_WIDTH;  out_pc  out  PC_WIDTH
  out_dmem_timeout  out  1  sticky timeout flag

Function
REQ-003 Inputs SHALL be sampled on each rising edge while out_stall=0; while out_stall=1 registers SHALL hold and upstream SHALL hold its outputs.
REQ-004 FSM SHALL have states IDLE, REQ, DONE; reset state IDLE.
REQ-005 IDLE: sampled load or store SHALL move to REQ next edge; otherwise remain IDLE.
REQ-006 Non-memory op: out_act_write_res_to_reg SHALL equal sampled flag and out_res SHALL equal sampled in_res in the cycle after sampling (latency 1).
REQ-007 REQ: dmem_req=1; dmem_addr, dmem_we, dmem_wdata SHALL stay stable until ack; out_stall=1; out_act_write_res_to_reg=0.
REQ-008 Store: dmem_we=1, dmem_addr=wr_addr, dmem_wdata=wr_word; load: dmem_we=0, dmem_addr=rd_addr, dmem_wdata=0.
REQ-009 Load and store both set SHALL perform store only; load suppressed.
REQ-010 dmem_ack SHALL be honoured only while dmem_req=1; on ack, load SHALL capture dmem_rdata into out_res; FSM to DONE.
REQ-011 Minimum load latency: ack in first REQ cycle yields writeback strobe 2 cycles after sampling.
REQ-012 DONE: out_stall=0, dmem_req=0, write strobe asserted exactly one cycle if sampled flag set; new inputs sampled this edge; next state per REQ-005.
REQ-013 Wait counter SHALL count REQ cycles without ack; reaching MAX_WAIT SHALL set out_dmem_timeout, drop request, suppress writeback, go DONE.
REQ-014 out_dmem_timeout SHALL stay set until reset.
REQ-015 Store SHALL never assert the write strobe unless in_act_write_res_to_reg was set (then writes in_res).

Reset
REQ-016 reset=0 SHALL asynchronously force IDLE, counter 0, all outputs 0, out_dmem_timeout 0.
REQ-017 Reset during REQ SHALL drop dmem_req immediately; transaction abandoned, no writeback.

Structure
REQ-018 Width defaults and FSM state encoding SHALL live in shared package swt16_pkg.
REQ-019 Wait counter SHALL be sub-module mem_wait_timer (clear, enable, MAX_WAIT compare, expired output).

Verification
REQ-020 ALU op: res=0x1234, idx=3, write=1 -> strobe one cycle, out_res=0x1234, idx 3, no dmem_req.
REQ-021 Load rd_addr=0x010, ack after 3 cycles, rdata=0xBEEF -> dmem_req 3 cycles, stall 3 cycles, out_res=0xBEEF strobe once.
REQ-022 Store wr_addr=0x020, word=0x00FF, ack in first cycle -> dmem_we=1 one cycle, no strobe, no further stall.
REQ-023 Load, no ack, MAX_WAIT=15 -> req drops after 15 cycles, out_dmem_timeout=1, no strobe.
REQ-024 Load and store both set -> store to wr_addr only, load address never driven.
REQ-025 reset=0 mid-REQ -> dmem_req=0 immediately, outputs 0, IDLE after release.
